// File: rtl/psx_scanout.sv
// psx_scanout: raster-order VRAM fetch, BGR555->RGB888 expansion and FIFO-buffered hand-off to the video block
module psx_scanout #(
  parameter int H_ACTIVE   = 720,
  parameter int V_ACTIVE   = 480,
  parameter int STRIDE     = 1024,
  parameter int ADDR_W     = 20,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_en,
  input  logic [ADDR_W-1:0] fb_base,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [15:0]       mem_rdata,
  output logic [23:0]       data,
  output logic              en,
  input  logic              rdy,
  output logic              frame_done,
  output logic              underflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = PW + 1;
  localparam int SW = OW + 1;
  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
  state_t state;
  logic [ADDR_W-1:0] line_base, cur_addr;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [OW-1:0] outstanding, fifo_count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [23:0] fifo_mem [FIFO_DEPTH];
  logic [23:0] rgb;
  logic push, pop, unused_msb;
  // Credits cover both buffered and in-flight pixels, so a return always has a free slot.
  assign mem_req = state == ACTIVE && ({1'b0, fifo_count} + {1'b0, outstanding}) < SW'(FIFO_DEPTH);
  assign mem_addr = cur_addr;
  assign push = mem_rvalid && outstanding != '0;
  assign pop = rdy && fifo_count != '0 && !en;
  assign rgb = {mem_rdata[4:0], mem_rdata[4:2], mem_rdata[9:5], mem_rdata[9:7],
                mem_rdata[14:10], mem_rdata[14:12]};
  assign unused_msb = mem_rdata[15];
  always_ff @(posedge clk)
    if (push) fifo_mem[wr_ptr] <= rgb;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      line_base   <= '0;
      cur_addr    <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      en          <= 1'b0;
      data        <= '0;
      frame_done  <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      en          <= pop;
      outstanding <= outstanding + OW'(mem_req) - OW'(push);
      fifo_count  <= fifo_count + OW'(push) - OW'(pop);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        data   <= fifo_mem[rd_ptr];
      end
      if (state == ACTIVE && rdy && fifo_count == '0) underflow <= 1'b1;
      case (state)
        IDLE:
          if (scan_en) begin
            line_base <= fb_base;
            cur_addr  <= fb_base;
            x         <= '0;
            y         <= '0;
            state     <= ACTIVE;
          end
        ACTIVE:
          if (mem_req) begin
            if (x == X_LAST) begin
              x         <= '0;
              y         <= y + YW'(1);
              line_base <= line_base + ADDR_W'(STRIDE);
              cur_addr  <= line_base + ADDR_W'(STRIDE);
              if (y == Y_LAST) state <= DRAIN;
            end else begin
              x        <= x + XW'(1);
              cur_addr <= cur_addr + ADDR_W'(1);
            end
          end
        DRAIN:
          // With nothing buffered or in flight, the pixel on en now is the frame's last.
          if (fifo_count == '0 && outstanding == '0 && en) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_psx_scanout.sv
// tb_psx_scanout: randomized scan-out bench with a raster/colour reference model and fixed-latency VRAM stub
module tb_psx_scanout;
  localparam int H = 12, V = 4, STRIDE = 32, AW = 12, DEPTH = 8, NPIX = H * V;
  logic clk = 1'b0, rst = 1'b0, scan_en = 1'b0, rdy = 1'b0;
  logic mem_req, en, frame_done, underflow;
  logic mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [AW-1:0] fb_base = '0, mem_addr;
  logic [23:0] data;
  psx_scanout #(.H_ACTIVE(H), .V_ACTIVE(V), .STRIDE(STRIDE), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .fb_base(fb_base), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .data(data),
    .en(en), .rdy(rdy), .frame_done(frame_done), .underflow(underflow)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [23:0] expand(input logic [15:0] v);
    int iv, r, g, b;
    iv = int'(v);
    r = iv % 32;
    g = (iv / 32) % 32;
    b = (iv / 1024) % 32;
    return 24'(((r * 8 + r / 4) << 16) + ((g * 8 + g / 4) << 8) + (b * 8 + b / 4));
  endfunction
  // VRAM stub: every request is answered exactly two cycles later
  logic [15:0] mem_img [1 << AW];
  logic p0v = 1'b0, p1v = 1'b0;
  logic [15:0] p0d = '0, p1d = '0;
  always @(negedge clk) begin
    mem_rvalid = p1v;
    mem_rdata  = p1v ? p1d : 16'($urandom);
    p1v = p0v;
    p1d = p0d;
    p0v = mem_req;
    p0d = mem_img[mem_addr];
  end
  // Reference model: raster address order and expected pixel stream
  logic [23:0] pix_q [$];
  logic [AW-1:0] model_base = '0, cur_base = '0, a;
  int req_idx = 0, pix_cnt = 0, nframes = 0;
  logic fd_exp = 1'b0, prev_en = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      req_idx = 0;
      pix_cnt = 0;
      fd_exp  = 1'b0;
      prev_en = 1'b0;
      pix_q.delete();
    end else begin
      chk("frame_done", 32'(frame_done), 32'(fd_exp));
      fd_exp = 1'b0;
      if (frame_done) nframes++;
      if (mem_req) begin
        if (req_idx == 0) cur_base = model_base;
        a = AW'(int'(cur_base) + (req_idx / H) * STRIDE + req_idx % H);
        chk("mem_addr", 32'(mem_addr), 32'(a));
        pix_q.push_back(expand(mem_img[a]));
        req_idx = (req_idx + 1) % NPIX;
      end
      if (en) begin
        chk("en_gap", 32'(prev_en), 0);
        if (pix_q.size() == 0) chk("en_without_pixel", 32'(en), 0);
        else chk("data", 32'(data), 32'(pix_q.pop_front()));
        pix_cnt++;
        if (pix_cnt == NPIX) begin
          fd_exp  = 1'b1;
          pix_cnt = 0;
        end
      end
      prev_en = en;
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_fd(input string tag, input bit rnd);
    int i = 0;
    while (frame_done !== 1'b1 && i < 3000) begin
      if (rnd) rdy = 1'($urandom_range(0, 1));
      step(1);
      i++;
    end
    chk({tag, "_done"}, 32'(frame_done), 1);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_en"}, 32'(en), 0);
    chk({tag, "_data"}, 32'(data), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_underflow"}, 32'(underflow), 0);
  endtask
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem_img[i] = 16'($urandom);
    mem_img[12'h100] = 16'h7FFF;
    mem_img[12'h101] = 16'h001F;
    mem_img[12'h102] = 16'h03E0;
    mem_img[12'h103] = 16'h7C00;
    mem_img[12'h104] = 16'h0421;
    mem_img[12'h105] = 16'hFFFF;
    mem_img[12'h106] = 16'h0000;
    fb_base = 12'h100;
    model_base = 12'h100;
    step(3);
    chk_reset("reset");
    rst = 1'b1;
    scan_en = 1'b1;
    step(30);
    chk("start_stall_req", 32'(mem_req), 0);
    chk("start_stall_en", 32'(en), 0);
    chk("start_stall_fill", 32'(pix_q.size()), DEPTH);
    chk("start_stall_underflow", 32'(underflow), 0);
    rdy = 1'b1;
    step(15);
    rdy = 1'b0;
    step(50);
    chk("mid_stall_req", 32'(mem_req), 0);
    chk("mid_stall_en", 32'(en), 0);
    chk("mid_stall_fill", 32'(pix_q.size()), DEPTH);
    rdy = 1'b1;
    fb_base = 12'hFF8;
    model_base = 12'hFF8;
    wait_fd("frame1", 1'b0);
    chk("underflow_clean", 32'(underflow), 0);
    step(2);
    chk("underflow_set", 32'(underflow), 1);
    step(10);
    scan_en = 1'b0;
    wait_fd("frame2", 1'b1);
    rdy = 1'b1;
    step(10);
    chk("stop_req", 32'(mem_req), 0);
    chk("stop_en", 32'(en), 0);
    chk("stop_queue", 32'(pix_q.size()), 0);
    chk("underflow_sticky", 32'(underflow), 1);
    fb_base = 12'h200;
    model_base = 12'h200;
    scan_en = 1'b1;
    step(25);
    rst = 1'b0;
    step(1);
    chk_reset("midframe_reset");
    rst = 1'b1;
    wait_fd("frame_restart", 1'b0);
    scan_en = 1'b0;
    step(5);
    chk("final_idle_req", 32'(mem_req), 0);
    chk("frame_count", 32'(nframes), 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
